jtdd_snd_mixn: RTL and testbench

Parametrised, time-multiplexed N-channel sound mixer for the sound subsystem. It sits between the sound sources (FM left/right, one or more ADPCM voices, future PCM chips) and the board audio output. On each sample strobe it snapshots all channel inputs. It then multiply-accumulates them through a single shared multiplier using CPU-programmable per-channel gains, and emits a saturated sample with a strobe, a held peak indicator and an overrun flag.

---
 rtl/jtdd_snd_mixn.sv | 143 ++++++++++++++
 tb/tb_jtdd_snd_mixn.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_snd_mixn.sv
// jtdd_snd_mixn: time-multiplexed N-channel sound mixer, one shared MAC.
// Ports: clk/rstn, cen strobe, ch_data, gain_we/addr/din, ovr_clr -> mixed, sample, busy, peak, ovr.
module jtdd_snd_mixn #(
  parameter int            CH        = 4,
  parameter int            W         = 16,
  parameter int            WOUT      = 16,
  parameter logic [7:0]    GAIN_RST  = 8'h10,
  parameter int            PEAK_HOLD = 64,
  localparam int           AW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cen,
  input  logic [CH*W-1:0]        ch_data,
  input  logic                   gain_we,
  input  logic [AW-1:0]          gain_addr,
  input  logic [7:0]             gain_din,
  input  logic                   ovr_clr,
  output logic signed [WOUT-1:0] mixed,
  output logic                   sample,
  output logic                   busy,
  output logic                   peak,
  output logic                   ovr
);

  localparam int PW   = $clog2(PEAK_HOLD + 1);
  localparam int ACCW = W + 9 + AW;
  localparam int EXW  = ACCW - W - 9;

  // Clamp limits in accumulator width (ACCW > WOUT for sane parameters).
  localparam logic signed [ACCW-1:0] MAXV =
    {{(ACCW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV =
    {{(ACCW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_SAT
  } st_t;

  st_t                   r_st;
  logic signed [ACCW-1:0] r_acc;
  logic [AW-1:0]         r_idx;
  logic [W-1:0]          r_snap [CH];
  logic [7:0]            r_gain [CH];
  logic [7:0]            r_shg  [CH];
  logic [PW-1:0]         r_pcnt;
  logic signed [WOUT-1:0] r_mixed;
  logic                  r_sample;
  logic                  r_peak;
  logic                  r_ovr;

  logic signed [W+8:0]   w_prod;
  logic signed [ACCW-1:0] w_prodx;
  logic signed [ACCW-1:0] w_sh;
  logic                  w_hi;
  logic                  w_lo;

  // Gain is zero-extended so the product stays signed.
  assign w_prod  = $signed(r_snap[r_idx]) * $signed({1'b0, r_shg[r_idx]});
  assign w_prodx = {{EXW{w_prod[W+8]}}, w_prod};
  assign w_sh    = r_acc >>> 4;
  assign w_hi    = (w_sh > MAXV);
  assign w_lo    = (w_sh < MINV);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < CH; k++) r_gain[k] <= GAIN_RST;
    end else if (gain_we && (int'(gain_addr) < CH)) begin
      r_gain[gain_addr] <= gain_din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st     <= S_IDLE;
      r_acc    <= '0;
      r_idx    <= '0;
      r_pcnt   <= '0;
      r_mixed  <= '0;
      r_sample <= 1'b0;
      r_peak   <= 1'b0;
      r_ovr    <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        r_snap[k] <= '0;
        r_shg[k]  <= GAIN_RST;
      end
    end else begin
      r_sample <= 1'b0;
      // Set wins over clear.
      if (cen && (r_st != S_IDLE)) r_ovr <= 1'b1;
      else if (ovr_clr)            r_ovr <= 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (cen) begin
            for (int k = 0; k < CH; k++) begin
              r_snap[k] <= ch_data[k*W +: W];
              r_shg[k]  <= r_gain[k];
            end
            r_acc <= '0;
            r_idx <= '0;
            r_st  <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prodx;
          if (r_idx == AW'(CH-1)) begin
            r_st <= S_SAT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_SAT: begin
          r_sample <= 1'b1;
          r_st     <= S_IDLE;
          if (w_hi) begin
            r_mixed <= MAXV[WOUT-1:0];
          end else if (w_lo) begin
            r_mixed <= MINV[WOUT-1:0];
          end else begin
            r_mixed <= w_sh[WOUT-1:0];
          end
          if (w_hi || w_lo) begin
            r_pcnt <= PW'(PEAK_HOLD);
            r_peak <= 1'b1;
          end else if (r_pcnt != '0) begin
            r_pcnt <= r_pcnt - 1'b1;
            r_peak <= (r_pcnt != PW'(1));
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

  assign mixed  = r_mixed;
  assign sample = r_sample;
  assign busy   = (r_st != S_IDLE);
  assign peak   = r_peak;
  assign ovr    = r_ovr;

endmodule

// File: tb/tb_jtdd_snd_mixn.sv
// tb_jtdd_snd_mixn: randomized self-checking bench for jtdd_snd_mixn.
// Reference model computes each mix with plain integer arithmetic.
module tb_jtdd_snd_mixn;

  localparam int CH = 4;
  localparam int W  = 16;
  localparam int PH = 3;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 cen = 1'b0;
  logic [CH*W-1:0]      ch_data = '0;
  logic                 gain_we = 1'b0;
  logic [1:0]           gain_addr = '0;
  logic [7:0]           gain_din = '0;
  logic                 ovr_clr = 1'b0;
  logic signed [15:0]   mixed;
  logic                 sample;
  logic                 busy;
  logic                 peak;
  logic                 ovr;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] d [CH];
  logic [7:0]         g [CH];
  int                 pk = 0;

  jtdd_snd_mixn #(
    .CH(CH), .W(W), .WOUT(16), .GAIN_RST(8'h10), .PEAK_HOLD(PH)
  ) dut (
    .clk(clk), .rstn(rstn), .cen(cen), .ch_data(ch_data),
    .gain_we(gain_we), .gain_addr(gain_addr), .gain_din(gain_din),
    .ovr_clr(ovr_clr), .mixed(mixed), .sample(sample), .busy(busy),
    .peak(peak), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected mix; also advances the peak-hold model.
  function automatic longint model_mix();
    longint s = 0;
    bit     sat;
    for (int k = 0; k < CH; k++) s += longint'(d[k]) * longint'(g[k]);
    s   = s >>> 4;
    sat = (s > 32767) || (s < -32768);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (sat) pk = PH;
    else if (pk > 0) pk--;
    return s;
  endfunction

  task automatic wr_gain(input int a, input logic [7:0] v);
    gain_we = 1'b1; gain_addr = 2'(a); gain_din = v;
    @(posedge clk); #1;
    gain_we = 1'b0;
    g[a] = v;
  endtask

  // mode 0 plain, 1 gain write at cycle 2, 2 overrun at cycle 3,
  // 3 overrun together with ovr_clr at cycle 3.
  task automatic run_mix(input int mode);
    longint e;
    int     n, bc;
    bit     seen;
    e = model_mix();
    for (int k = 0; k < CH; k++) ch_data[k*W +: W] = d[k];
    cen = 1'b1;
    n = 0; bc = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        cen = 1'b0;
        ch_data = '0;
      end
      if (mode == 1 && n == 2) begin
        gain_we = 1'b1; gain_addr = 2'd0; gain_din = 8'h20;
      end
      if (mode == 1 && n == 3) begin
        gain_we = 1'b0; g[0] = 8'h20;
      end
      if (mode >= 2 && n == 3) begin
        cen = 1'b1;
        ovr_clr = (mode == 3);
      end
      if (mode >= 2 && n == 4) begin
        cen = 1'b0; ovr_clr = 1'b0;
        chk("ovr_set", ovr, 1);
      end
      if (sample) seen = 1;
      else if (busy) bc++;
    end
    chk("mixed", mixed, e);
    chk("latency", n, CH + 2);
    chk("busy_len", bc, CH + 1);
    chk("peak", peak, pk != 0);
    @(posedge clk); #1;
    chk("pulse_w", sample, 0);
  endtask

  initial begin
    int sc;
    for (int k = 0; k < CH; k++) g[k] = 8'h10;
    #12;
    chk("rst_mixed", mixed, 0);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_peak", peak, 0);
    chk("rst_ovr", ovr, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    d[0] = 1000; d[1] = 2000; d[2] = -500; d[3] = 0;
    run_mix(0);
    chk("unity", mixed, 2500);

    wr_gain(0, 8'h08);
    for (int k = 1; k < CH; k++) wr_gain(k, 8'h00);
    for (int k = 1; k < CH; k++) d[k] = 16'($urandom);
    d[0] = 3;  run_mix(0);
    chk("round_pos", mixed, 1);
    d[0] = -3; run_mix(0);
    chk("round_neg", mixed, -2);

    for (int k = 0; k < CH; k++) wr_gain(k, 8'h10);
    d[0] = 16'h7000; d[1] = 16'h7000; d[2] = 0; d[3] = 0;
    run_mix(0);
    chk("sat_hi", mixed, 32767);
    chk("peak_hi", peak, 1);
    d[0] = -16'sh7000; d[1] = -16'sh7000;
    run_mix(0);
    chk("sat_lo", mixed, -32768);
    for (int q = 0; q < 3; q++) begin
      for (int k = 0; k < CH; k++) d[k] = 16'($urandom_range(0, 200)) - 16'd100;
      run_mix(0);
      chk("peak_hold", peak, q < 2);
    end

    for (int k = 0; k < CH; k++) d[k] = 16'($urandom_range(0, 2000)) - 16'd1000;
    run_mix(1);
    run_mix(0);

    run_mix(2);
    sc = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (sample) sc++;
    end
    chk("no_extra", sc, 0);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("ovr_clr", ovr, 0);
    run_mix(3);
    chk("ovr_keep", ovr, 1);

    d[0] = 16'h7FFF; d[1] = 16'h7FFF; d[2] = 16'h7FFF; d[3] = 16'h7FFF;
    run_mix(0);
    wr_gain(1, 8'h30);
    for (int k = 0; k < CH; k++) ch_data[k*W +: W] = 16'h4000;
    cen = 1'b1;
    @(posedge clk); #1;
    cen = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("arst_mixed", mixed, 0);
    chk("arst_busy", busy, 0);
    chk("arst_peak", peak, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_sample", sample, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    sc = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (sample) sc++;
    end
    chk("abandon", sc, 0);
    for (int k = 0; k < CH; k++) g[k] = 8'h10;
    pk = 0;
    d[0] = 100; d[1] = -7; d[2] = 33; d[3] = 1;
    run_mix(0);
    chk("rst_gain", mixed, 127);

    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 3) == 0) wr_gain(k, 8'($urandom));
        if (t % 2 == 0) d[k] = 16'($urandom);
        else d[k] = 16'($urandom_range(0, 4000)) - 16'd2000;
      end
      run_mix(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
